score_tracker: RTL

SCORE_TRACKER -- requirements
Module: score_tracker

---
 rtl/game_pkg.sv | 35 +++
 rtl/bcd_counter2.sv | 54 +++++
 rtl/score_tracker.sv | 138 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared encodings for the score tracker FSM and its seven-segment/LED display stage.
package game_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_WIN  = 2'd2;
  localparam logic [1:0] ST_LOSE = 2'd3;

  localparam logic [3:0] MODE_IDLE = 4'h0;
  localparam logic [3:0] MODE_PLAY = 4'h1;
  localparam logic [3:0] MODE_WIN  = 4'hA;
  localparam logic [3:0] MODE_LOSE = 4'hE;
  localparam logic [3:0] BLANK     = 4'hF;

  function automatic logic [3:0] mode_code(input logic [1:0] st);
    logic [3:0] code;
    case (st)
      ST_PLAY: code = MODE_PLAY;
      ST_WIN:  code = MODE_WIN;
      ST_LOSE: code = MODE_LOSE;
      default: code = MODE_IDLE;
    endcase
    return code;
  endfunction

  // A leading zero on the tens digit is shown as a dark segment.
  function automatic logic [3:0] tens_display(input logic [3:0] tens);
    return (tens == 4'd0) ? BLANK : tens;
  endfunction

  function automatic logic is_over(input logic [1:0] st);
    return (st == ST_WIN) || (st == ST_LOSE);
  endfunction

endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score register that saturates at MAX_VALUE; exposes its next value
// so the owner can act in the same cycle the ceiling is reached.
module bcd_counter2 #(
  parameter int MAX_VALUE = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear_i,
  input  logic       inc_i,
  output logic [3:0] tens_d_o,
  output logic [3:0] ones_d_o,
  output logic       at_max_d_o
);

  localparam logic [3:0] MAX_TENS = 4'(MAX_VALUE / 10);
  localparam logic [3:0] MAX_ONES = 4'(MAX_VALUE % 10);

  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       at_max_q;

  assign at_max_q = (tens_q == MAX_TENS) && (ones_q == MAX_ONES);

  always_comb begin
    tens_d = tens_q;
    ones_d = ones_q;
    if (clear_i) begin
      tens_d = 4'd0;
      ones_d = 4'd0;
    end else if (inc_i && !at_max_q) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens_q <= 4'd0;
      ones_q <= 4'd0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  end

  assign tens_d_o   = tens_d;
  assign ones_d_o   = ones_d;
  assign at_max_d_o = (tens_d == MAX_TENS) && (ones_d == MAX_ONES);

endmodule

// File: rtl/score_tracker.sv
// Memory-game score/lives tracker: IDLE/PLAY/WIN/LOSE FSM with registered
// seven-segment codes and a lives bar that flashes once the game ends.
module score_tracker
  import game_pkg::*;
#(
  parameter int MAX_SCORE    = 32,
  parameter int LIVES        = 10,
  parameter int FLASH_CYCLES = 25_000_000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       match,
  input  logic       miss,
  input  logic       userquit,
  output logic       ingameOn,
  output logic       gameOver,
  output logic [3:0] hex0hldr,
  output logic [3:0] hex4hldr,
  output logic [3:0] hex5hldr,
  output logic [9:0] ledrhldr
);

  localparam int               CNT_W      = (FLASH_CYCLES > 1) ? $clog2(FLASH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(FLASH_CYCLES - 1);
  localparam logic [3:0]       LIVES_INIT = 4'(LIVES);

  logic [1:0]       state_q, state_d;
  logic [3:0]       lives_q, lives_d;
  logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
  logic             flash_on_q, flash_on_d;
  logic             ingame_q, gameover_q;
  logic [3:0]       hex0_q, hex4_q, hex5_q;
  logic [9:0]       ledr_q, ledr_d;
  logic [9:0]       therm;

  logic       score_clr, score_inc, score_hit;
  logic [3:0] tens_d, ones_d;

  assign score_clr = (state_q != ST_PLAY) && start;
  assign score_inc = (state_q == ST_PLAY) && !userquit && match;

  bcd_counter2 #(
    .MAX_VALUE (MAX_SCORE)
  ) u_score (
    .clk        (clock),
    .rst_n      (resetn),
    .clear_i    (score_clr),
    .inc_i      (score_inc),
    .tens_d_o   (tens_d),
    .ones_d_o   (ones_d),
    .at_max_d_o (score_hit)
  );

  // Quit overrides the pulses; otherwise both pulses apply and a win outranks a loss.
  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    case (state_q)
      ST_PLAY: begin
        if (userquit) begin
          state_d = ST_LOSE;
        end else begin
          if (miss && (lives_q != 4'd0)) lives_d = lives_q - 4'd1;
          if (score_hit)               state_d = ST_WIN;
          else if (lives_d == 4'd0)    state_d = ST_LOSE;
        end
      end
      default: begin
        if (start) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
        end
      end
    endcase
  end

  // The flash phase restarts lit on every entry into an end state.
  always_comb begin
    flash_cnt_d = '0;
    flash_on_d  = 1'b1;
    if (is_over(state_d) && is_over(state_q)) begin
      if (flash_cnt_q == CNT_LAST) begin
        flash_on_d = ~flash_on_q;
      end else begin
        flash_cnt_d = flash_cnt_q + 1'b1;
        flash_on_d  = flash_on_q;
      end
    end
  end

  for (genvar gi = 0; gi < 10; gi++) begin : g_therm
    assign therm[gi] = (lives_d > 4'(gi));
  end

  always_comb begin
    ledr_d = '0;
    case (state_d)
      ST_PLAY:         ledr_d = therm;
      ST_WIN, ST_LOSE: ledr_d = flash_on_d ? 10'h3FF : 10'h000;
      default:         ledr_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      lives_q     <= LIVES_INIT;
      flash_cnt_q <= '0;
      flash_on_q  <= 1'b1;
      ingame_q    <= 1'b0;
      gameover_q  <= 1'b0;
      hex0_q      <= MODE_IDLE;
      hex4_q      <= 4'd0;
      hex5_q      <= BLANK;
      ledr_q      <= '0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      flash_cnt_q <= flash_cnt_d;
      flash_on_q  <= flash_on_d;
      ingame_q    <= (state_d == ST_PLAY);
      gameover_q  <= is_over(state_d);
      hex0_q      <= mode_code(state_d);
      hex4_q      <= ones_d;
      hex5_q      <= tens_display(tens_d);
      ledr_q      <= ledr_d;
    end
  end

  assign ingameOn = ingame_q;
  assign gameOver = gameover_q;
  assign hex0hldr = hex0_q;
  assign hex4hldr = hex4_q;
  assign hex5hldr = hex5_q;
  assign ledrhldr = ledr_q;

endmodule
